// File: rtl/counter_modulo_ctrl.sv
// Run controller for a modulo counter: counts tck cycles modulo cfg_mod, for
// cfg_rpt periods or continuously. Configuration is staged in shadow registers.
module counter_modulo_ctrl #(
  parameter int WIDTH     = 32,
  parameter int RPT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 tck,
  input  logic                 cfg_vld,
  output logic                 cfg_rdy,
  input  logic [WIDTH:0]       cfg_mod,
  input  logic [RPT_WIDTH-1:0] cfg_rpt,
  output logic [WIDTH-1:0]     cnt,
  output logic                 wrp,
  output logic [RPT_WIDTH-1:0] rpt,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [RPT_WIDTH-1:0] rpt_q, rpt_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       act_mod_q, act_mod_d;
  logic [RPT_WIDTH-1:0] act_rpt_q, act_rpt_d;
  logic [WIDTH:0]       sh_mod_q, sh_mod_d;
  logic [RPT_WIDTH-1:0] sh_rpt_q, sh_rpt_d;
  logic                 sh_pend_q, sh_pend_d;

  logic [WIDTH:0]       eff_mod;
  logic [WIDTH:0]       mod_m1;
  logic [RPT_WIDTH-1:0] rpt_inc;
  logic                 wrp_c;
  logic                 last_period;
  logic                 cfg_hs;
  logic                 copy;

  // Compare in WIDTH+1 bits so mod=2^WIDTH wraps at all-ones.
  assign eff_mod     = sh_pend_q ? sh_mod_q : act_mod_q;
  assign mod_m1      = act_mod_q - 1'b1;
  assign wrp_c       = (state_q == RUN) & tck & ~stop & ({1'b0, cnt_q} == mod_m1);
  assign rpt_inc     = rpt_q + 1'b1;
  assign last_period = (act_rpt_q != '0) && (rpt_inc == act_rpt_q);
  assign cfg_hs      = cfg_vld & ~sh_pend_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    done_d    = 1'b0;
    act_mod_d = act_mod_q;
    act_rpt_d = act_rpt_q;
    sh_mod_d  = sh_mod_q;
    sh_rpt_d  = sh_rpt_q;
    sh_pend_d = sh_pend_q;
    copy      = 1'b0;

    case (state_q)
      IDLE: begin
        copy  = sh_pend_q;
        cnt_d = '0;
        if (start && !stop && (eff_mod != '0)) begin
          state_d = RUN;
          rpt_d   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (wrp_c) begin
          cnt_d = '0;
          rpt_d = rpt_inc;
          copy  = sh_pend_q;
          if (last_period) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (tck) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // copy only happens with sh_pend=1, handshake only with sh_pend=0
    if (copy) begin
      act_mod_d = sh_mod_q;
      act_rpt_d = sh_rpt_q;
      sh_pend_d = 1'b0;
    end
    if (cfg_hs) begin
      sh_mod_d  = cfg_mod;
      sh_rpt_d  = cfg_rpt;
      sh_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rpt_q     <= '0;
      done_q    <= 1'b0;
      act_mod_q <= '0;
      act_rpt_q <= '0;
      sh_mod_q  <= '0;
      sh_rpt_q  <= '0;
      sh_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      done_q    <= done_d;
      act_mod_q <= act_mod_d;
      act_rpt_q <= act_rpt_d;
      sh_mod_q  <= sh_mod_d;
      sh_rpt_q  <= sh_rpt_d;
      sh_pend_q <= sh_pend_d;
    end
  end

  assign cfg_rdy = ~sh_pend_q;
  assign cnt     = cnt_q;
  assign wrp     = wrp_c;
  assign rpt     = rpt_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_counter_modulo_ctrl.sv
// Directed bench for counter_modulo_ctrl (WIDTH=4) with hand-computed expectations.
module tb_counter_modulo_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       tck;
  logic       cfg_vld;
  logic       cfg_rdy;
  logic [4:0] cfg_mod;
  logic [7:0] cfg_rpt;
  logic [3:0] cnt;
  logic       wrp;
  logic [7:0] rpt;
  logic       busy;
  logic       done;

  int n_tot = 0;
  int n_bad = 0;

  counter_modulo_ctrl #(.WIDTH(4), .RPT_WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .tck     (tck),
    .cfg_vld (cfg_vld),
    .cfg_rdy (cfg_rdy),
    .cfg_mod (cfg_mod),
    .cfg_rpt (cfg_rpt),
    .cnt     (cnt),
    .wrp     (wrp),
    .rpt     (rpt),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Handshake one configuration, then allow the idle shadow-to-active copy.
  task automatic cfg_write(input logic [4:0] m, input logic [7:0] r);
    int k;
    k = 0;
    while (!cfg_rdy && k < 50) begin
      cyc();
      k++;
    end
    chk("cfg_rdy_wait", {31'd0, cfg_rdy}, 32'd1);
    cfg_vld = 1'b1;
    cfg_mod = m;
    cfg_rpt = r;
    cyc();
    cfg_vld = 1'b0;
    cyc();
    $display("cfg write mod=%0d rpt=%0d", m, r);
  endtask

  initial begin
    int exp_c[6] = '{0, 1, 2, 0, 1, 2};
    int exp_w[6] = '{0, 0, 1, 0, 0, 1};
    int m_cnt, ntck, first, dseen;
    logic exp_wrp;

    rst = 1'b1; start = 1'b0; stop = 1'b0; tck = 1'b0;
    cfg_vld = 1'b0; cfg_mod = '0; cfg_rpt = '0;

    // reset state
    cyc(); cyc(); #3;
    chk("rst_cnt", {28'd0, cnt}, 0);
    chk("rst_rpt", {24'd0, rpt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_wrp", {31'd0, wrp}, 0);
    chk("rst_rdy", {31'd0, cfg_rdy}, 1);
    cyc();
    rst = 1'b0;
    cyc();

    // start with mod=0 after reset is ignored
    tck = 1'b1;
    go(); #3;
    chk("mod0_busy", {31'd0, busy}, 0);
    cyc();
    $display("txn start with mod=0 done");

    // finite run mod=3 rpt=2, after a start+stop collision in IDLE
    cfg_write(5'd3, 8'd2);
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0; #3;
    chk("startstop_busy", {31'd0, busy}, 0);
    cyc();
    go();
    for (int i = 0; i < 6; i++) begin
      #3;
      chk("fin_cnt", {28'd0, cnt}, exp_c[i]);
      chk("fin_wrp", {31'd0, wrp}, exp_w[i]);
      chk("fin_busy", {31'd0, busy}, 1);
      cyc();
    end
    #3;
    chk("fin_done", {31'd0, done}, 1);
    chk("fin_busy_end", {31'd0, busy}, 0);
    chk("fin_rpt", {24'd0, rpt}, 2);
    chk("fin_cnt_end", {28'd0, cnt}, 0);
    cyc(); #3;
    chk("fin_done_1cyc", {31'd0, done}, 0);
    cyc();
    $display("txn finite run mod=3 rpt=2 done");

    // tick gating, mod=4 continuous
    cfg_write(5'd4, 8'd0);
    tck = 1'b0;
    go();
    m_cnt = 0; ntck = 0; first = 0; dseen = 0;
    for (int i = 0; i < 24; i++) begin
      tck = (i % 2 == 0);
      #3;
      exp_wrp = tck && (m_cnt == 3);
      chk("gate_cnt", {28'd0, cnt}, m_cnt);
      chk("gate_wrp", {31'd0, wrp}, {31'd0, exp_wrp});
      if (done) dseen = 1;
      if (tck) begin
        ntck++;
        if (wrp && first == 0) first = ntck;
        m_cnt = exp_wrp ? 0 : m_cnt + 1;
      end
      cyc();
    end
    #3;
    chk("gate_first_wrp", first, 4);
    chk("gate_rpt", {24'd0, rpt}, 3);
    chk("gate_no_done", dseen, 0);
    chk("gate_busy", {31'd0, busy}, 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    $display("txn tick gating mod=4 done");

    // shadow update mid-run: mod 5 -> 2
    cfg_write(5'd5, 8'd0);
    tck = 1'b1;
    go();
    cyc();
    cfg_vld = 1'b1; cfg_mod = 5'd2; cfg_rpt = 8'd0; #3;
    chk("sh_cnt1", {28'd0, cnt}, 1);
    chk("sh_rdy_before", {31'd0, cfg_rdy}, 1);
    cyc();
    cfg_vld = 1'b0; #3;
    chk("sh_cnt2", {28'd0, cnt}, 2);
    chk("sh_rdy_pend", {31'd0, cfg_rdy}, 0);
    cyc(); #3;
    chk("sh_cnt3", {28'd0, cnt}, 3);
    chk("sh_rdy_pend3", {31'd0, cfg_rdy}, 0);
    cyc(); #3;
    chk("sh_cnt4", {28'd0, cnt}, 4);
    chk("sh_wrp4", {31'd0, wrp}, 1);
    chk("sh_rdy_wrap", {31'd0, cfg_rdy}, 0);
    cyc(); #3;
    chk("sh_new_cnt0", {28'd0, cnt}, 0);
    chk("sh_new_wrp0", {31'd0, wrp}, 0);
    chk("sh_rdy_back", {31'd0, cfg_rdy}, 1);
    cyc(); #3;
    chk("sh_new_cnt1", {28'd0, cnt}, 1);
    chk("sh_new_wrp1", {31'd0, wrp}, 1);
    cyc(); #3;
    chk("sh_new_cnt_wrap", {28'd0, cnt}, 0);
    chk("sh_rpt", {24'd0, rpt}, 2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    $display("txn shadow update 5->2 done");

    // abort at cnt=3 with tck=1 on mod=4 (stop beats the wrap)
    cfg_write(5'd4, 8'd0);
    go();
    repeat (7) cyc();
    stop = 1'b1; #3;
    chk("abort_cnt3", {28'd0, cnt}, 3);
    chk("abort_wrp", {31'd0, wrp}, 0);
    cyc();
    stop = 1'b0; #3;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_cnt", {28'd0, cnt}, 0);
    chk("abort_rpt", {24'd0, rpt}, 1);
    chk("abort_done", {31'd0, done}, 0);
    cyc(); #3;
    chk("abort_done2", {31'd0, done}, 0);
    cyc();
    $display("txn abort mod=4 done");

    // mod=1: wrap on every tick
    cfg_write(5'd1, 8'd0);
    go();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("m1_cnt", {28'd0, cnt}, 0);
      chk("m1_wrp", {31'd0, wrp}, 1);
      chk("m1_rpt", {24'd0, rpt}, i);
      cyc();
    end
    tck = 1'b0; #3;
    chk("m1_wrp_notck", {31'd0, wrp}, 0);
    chk("m1_rpt_end", {24'd0, rpt}, 3);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    $display("txn mod=1 done");

    // mod=2^WIDTH, one period
    cfg_write(5'd16, 8'd1);
    tck = 1'b1;
    go();
    for (int i = 0; i < 16; i++) begin
      #3;
      chk("m16_cnt", {28'd0, cnt}, i);
      chk("m16_wrp", {31'd0, wrp}, (i == 15) ? 1 : 0);
      cyc();
    end
    #3;
    chk("m16_done", {31'd0, done}, 1);
    chk("m16_busy", {31'd0, busy}, 0);
    chk("m16_rpt", {24'd0, rpt}, 1);
    cyc(); #3;
    chk("m16_done2", {31'd0, done}, 0);
    cyc();
    $display("txn mod=16 done");

    // reset mid-run at cnt=2
    cfg_write(5'd3, 8'd0);
    go();
    cyc(); cyc(); #3;
    chk("rmr_cnt2", {28'd0, cnt}, 2);
    rst = 1'b1; #1;
    chk("rmr_async_cnt", {28'd0, cnt}, 0);
    chk("rmr_async_busy", {31'd0, busy}, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("rmr_done", {31'd0, done}, 0);
      chk("rmr_busy", {31'd0, busy}, 0);
      chk("rmr_cnt", {28'd0, cnt}, 0);
      chk("rmr_rpt", {24'd0, rpt}, 0);
      chk("rmr_wrp", {31'd0, wrp}, 0);
      chk("rmr_rdy", {31'd0, cfg_rdy}, 1);
      cyc();
    end
    go(); #3;
    chk("rmr_start_ignored", {31'd0, busy}, 0);
    cyc();
    $display("txn reset mid-run done");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
